fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock and reset ports are i_clk and i_rst, and every register samples i_rst only on the rising edge of i_clk.
REQ-002 Parameter ENTRY_W, default 64, SHALL set the width of one queued instruction record in bits.
REQ-003 Parameter ENQ_W, default 4, SHALL set the maximum number of records enqueued per cycle.
REQ-004 Parameter DEQ_W, default 4, SHALL set the maximum number of records presented and dequeued per cycle.
REQ-005 Parameter DEPTH, default 16, SHALL set the number of storage entries; it is a power of two and at least ENQ_W+DEQ_W.
REQ-006 i_clk  input  1  clock.
REQ-007 i_rst  input  1  synchronous active-high reset.
REQ-008 i_flush  input  1  discard all queued records.
REQ-009 i_enq_count  input  clog2(ENQ_W+1)  number of valid lanes offered, occupying lanes 0..count-1.
REQ-010 i_enq_data  input  ENQ_W*ENTRY_W  enqueue lanes; lane k is bits [k*ENTRY_W +: ENTRY_W].
REQ-011 o_enq_ready  output  1  queue accepts a full ENQ_W group this cycle.
REQ-012 o_deq_valid  output  DEQ_W  thermometer mask of valid output lanes, lane 0 is oldest.
REQ-013 o_deq_data  output  DEQ_W*ENTRY_W  oldest records in age order.
REQ-014 i_deq_count  input  clog2(DEQ_W+1)  number of presented records consumed this cycle.
REQ-015 o_count  output  clog2(DEPTH+1)  current occupancy.

Function
REQ-016 Storage SHALL be a circular buffer with head and tail pointers of clog2(DEPTH) bits; all pointer arithmetic SHALL wrap modulo DEPTH.
REQ-017 o_enq_ready SHALL equal (DEPTH - o_count) >= ENQ_W, derived from registered occupancy only, with no combinational path from i_deq_count.
REQ-018 When o_enq_ready=1 and i_flush=0, lanes 0..i_enq_count-1 SHALL be written at tail, tail+1, ... in lane order, and tail SHALL advance by i_enq_count.
REQ-019 When o_enq_ready=0, the offered group SHALL be dropped in full; no partial enqueue is permitted.
REQ-020 o_deq_valid lane k SHALL be 1 iff k < o_count; o_deq_data lane k SHALL show entry head+k (mod DEPTH), and invalid lanes carry don't-care data.
REQ-021 The effective dequeue SHALL be min(i_deq_count, number of valid lanes); head SHALL advance by that amount.
REQ-022 Enqueue and dequeue in the same cycle SHALL both take effect: next o_count = o_count + accepted enq - effective deq.
REQ-023 There SHALL be no bypass: a record enqueued in cycle N is first visible on o_deq_* in cycle N+1.
REQ-024 When i_flush=1, head, tail and o_count SHALL be cleared to 0 on the next edge, overriding any same-cycle enqueue or dequeue.
REQ-025 i_enq_count > ENQ_W and i_deq_count > DEQ_W are illegal; the design SHALL clamp them to ENQ_W and DEQ_W respectively.
REQ-026 Storage contents SHALL NOT require reset; only pointers and occupancy are reset.

Reset
REQ-027 While i_rst=1, on each rising edge head, tail and o_count SHALL be set to 0; in the following cycle o_deq_valid=0 and o_enq_ready=1.
REQ-028 i_rst SHALL override i_flush, enqueue and dequeue in the same cycle; an operation in flight when i_rst asserts is discarded.

Verification
REQ-029 Reset: hold i_rst=1 for 1 cycle with i_enq_count=4 -> next cycle o_count=0, o_deq_valid=4'b0000, o_enq_ready=1.
REQ-030 Basic: enqueue count 3 with A,B,C at cycle 0 and i_deq_count=0 -> cycle 1 o_deq_valid=4'b0111, lanes 0..2 = A,B,C, o_count=3.
REQ-031 Full: four enqueues of 4 -> o_count=16, o_enq_ready=0; offer 4 more -> dropped, o_count stays 16; at o_count=13, o_enq_ready=0.
REQ-032 Wrap: at o_count=10 with head=12, enqueue 4 and dequeue 2 -> o_count=12, head=14; oldest-first order is preserved across index 15->0.
REQ-033 Clamp: o_count=2 with i_deq_count=3 -> effective dequeue is 2, next o_count=0, o_deq_valid=4'b0000.
REQ-034 Flush: o_count=9 with simultaneous enqueue 4, dequeue 4 and i_flush=1 -> next cycle o_count=0, o_deq_valid=0, o_enq_ready=1.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Enqueue/dequeue bundle for fetch_queue: the producer group, the consumer
// window and the occupancy. Clock and reset stay on the module.
interface fetch_queue_if #(
  parameter int ENTRY_W = 64,
  parameter int ENQ_W   = 4,
  parameter int DEQ_W   = 4,
  parameter int DEPTH   = 16
);
  localparam int ENQ_CW = $clog2(ENQ_W + 1);
  localparam int DEQ_CW = $clog2(DEQ_W + 1);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                       i_flush;
  logic [ENQ_CW-1:0]          i_enq_count;
  logic [ENQ_W*ENTRY_W-1:0]   i_enq_data;
  logic                       o_enq_ready;
  logic [DEQ_W-1:0]           o_deq_valid;
  logic [DEQ_W*ENTRY_W-1:0]   o_deq_data;
  logic [DEQ_CW-1:0]          i_deq_count;
  logic [CNT_W-1:0]           o_count;

  modport master (
    output i_flush, i_enq_count, i_enq_data, i_deq_count,
    input  o_enq_ready, o_deq_valid, o_deq_data, o_count
  );

  modport slave (
    input  i_flush, i_enq_count, i_enq_data, i_deq_count,
    output o_enq_ready, o_deq_valid, o_deq_data, o_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Multi-lane circular fetch queue: up to ENQ_W records in and DEQ_W out per
// cycle, oldest record presented on lane 0, no enqueue-to-dequeue bypass.
module fetch_queue #(
  parameter int ENTRY_W = 64,
  parameter int ENQ_W   = 4,
  parameter int DEQ_W   = 4,
  parameter int DEPTH   = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fetch_queue_if.slave   bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ENQ_CW = $clog2(ENQ_W + 1);
  localparam int DEQ_CW = $clog2(DEQ_W + 1);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [CNT_W-1:0]   free_s;
  logic               enq_ready_s;
  logic [ENQ_CW-1:0]  enq_clamp_s;
  logic [ENQ_CW-1:0]  enq_acc_s;
  logic [DEQ_CW-1:0]  deq_clamp_s;
  logic [CNT_W-1:0]   avail_s;
  logic [CNT_W-1:0]   deq_eff_s;

  // Admission and pointer next-state; readiness uses registered occupancy only
  always_comb begin
    free_s      = CNT_W'(DEPTH) - count_q;
    enq_ready_s = (free_s >= CNT_W'(ENQ_W));
    enq_clamp_s = (bus.i_enq_count > ENQ_CW'(ENQ_W)) ? ENQ_CW'(ENQ_W) : bus.i_enq_count;
    if (enq_ready_s && !bus.i_flush && !i_rst) begin
      enq_acc_s = enq_clamp_s;
    end else begin
      enq_acc_s = '0;
    end
    deq_clamp_s = (bus.i_deq_count > DEQ_CW'(DEQ_W)) ? DEQ_CW'(DEQ_W) : bus.i_deq_count;
    avail_s     = (count_q > CNT_W'(DEQ_W)) ? CNT_W'(DEQ_W) : count_q;
    deq_eff_s   = (CNT_W'(deq_clamp_s) < avail_s) ? CNT_W'(deq_clamp_s) : avail_s;
    if (bus.i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_eff_s);
      tail_d  = tail_q + PTR_W'(enq_acc_s);
      count_d = count_q + CNT_W'(enq_acc_s) - deq_eff_s;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Record storage; lanes beyond the accepted count leave entries untouched
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < ENQ_W; k++) begin
      if (ENQ_CW'(k) < enq_acc_s) begin
        mem_q[tail_q + PTR_W'(k)] <= bus.i_enq_data[k*ENTRY_W +: ENTRY_W];
      end
    end
  end

  for (genvar k = 0; k < DEQ_W; k++) begin : g_deq_lane
    assign bus.o_deq_valid[k]                       = (count_q > CNT_W'(k));
    assign bus.o_deq_data[k*ENTRY_W +: ENTRY_W]     = mem_q[head_q + PTR_W'(k)];
  end

  assign bus.o_enq_ready = enq_ready_s;
  assign bus.o_count     = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, basic enqueue, full/drop, clamps,
// flush priority and pointer wrap, each with hand-computed expectations.
module tb_fetch_queue;
  localparam int ENTRY_W = 64;
  localparam int ENQ_W   = 4;
  localparam int DEQ_W   = 4;
  localparam int DEPTH   = 16;

  logic i_clk;
  logic i_rst;
  int   checks;
  int   errors;

  fetch_queue_if #(.ENTRY_W(ENTRY_W), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.ENTRY_W(ENTRY_W), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DEPTH(DEPTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [63:0] rec(input int n);
    return 64'hF00D_0000_0000_0000 | 64'(n);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input int enq_n, input int base, input int deq_n, input logic flush);
    bus.i_enq_count = 3'(enq_n);
    for (int k = 0; k < ENQ_W; k++) begin
      bus.i_enq_data[k*ENTRY_W +: ENTRY_W] = rec(base + k);
    end
    bus.i_deq_count = 3'(deq_n);
    bus.i_flush     = flush;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lane(input int k);
    return bus.o_deq_data[k*ENTRY_W +: ENTRY_W];
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    i_rst  = 1'b1;
    drive(4, 200, 0, 1'b0);
    tick();
    i_rst = 1'b0;
    drive(0, 0, 0, 1'b0);
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_valid", 64'(bus.o_deq_valid), 64'h0);
    chk("rst_ready", 64'(bus.o_enq_ready), 64'd1);

    // basic enqueue of three, visible only the next cycle
    drive(3, 1, 0, 1'b0);
    chk("nobypass_valid", 64'(bus.o_deq_valid), 64'h0);
    tick();
    drive(0, 0, 0, 1'b0);
    chk("basic_valid", 64'(bus.o_deq_valid), 64'h7);
    chk("basic_l0", lane(0), rec(1));
    chk("basic_l1", lane(1), rec(2));
    chk("basic_l2", lane(2), rec(3));
    chk("basic_count", 64'(bus.o_count), 64'd3);

    // dequeue one, then over-request three with only two present
    drive(0, 0, 1, 1'b0);
    tick();
    chk("deq1_count", 64'(bus.o_count), 64'd2);
    chk("deq1_l0", lane(0), rec(2));
    drive(0, 0, 3, 1'b0);
    tick();
    drive(0, 0, 0, 1'b0);
    chk("clamp_count", 64'(bus.o_count), 64'd0);
    chk("clamp_valid", 64'(bus.o_deq_valid), 64'h0);

    // fill to capacity, head=3
    drive(4, 10, 0, 1'b0); tick();
    drive(4, 14, 0, 1'b0); tick();
    drive(4, 18, 0, 1'b0); tick();
    chk("c12_ready", 64'(bus.o_enq_ready), 64'd1);
    drive(4, 22, 0, 1'b0); tick();
    chk("full_count", 64'(bus.o_count), 64'd16);
    chk("full_ready", 64'(bus.o_enq_ready), 64'd0);
    drive(4, 90, 0, 1'b0); tick();
    chk("drop_count", 64'(bus.o_count), 64'd16);
    chk("drop_valid", 64'(bus.o_deq_valid), 64'hF);
    chk("drop_l0", lane(0), rec(10));
    chk("drop_l3", lane(3), rec(13));
    drive(0, 0, 3, 1'b0); tick();
    chk("c13_count", 64'(bus.o_count), 64'd13);
    chk("c13_ready", 64'(bus.o_enq_ready), 64'd0);
    chk("c13_l0", lane(0), rec(13));
    drive(0, 0, 4, 1'b0); tick();
    chk("c9_count", 64'(bus.o_count), 64'd9);

    // flush overrides simultaneous enqueue and dequeue
    drive(4, 60, 4, 1'b1); tick();
    drive(0, 0, 0, 1'b0);
    chk("flush_count", 64'(bus.o_count), 64'd0);
    chk("flush_valid", 64'(bus.o_deq_valid), 64'h0);
    chk("flush_ready", 64'(bus.o_enq_ready), 64'd1);

    // walk head to 12 with 10 records queued
    drive(4, 20, 0, 1'b0); tick();
    drive(4, 24, 4, 1'b0); tick();
    drive(4, 28, 4, 1'b0); tick();
    drive(4, 32, 4, 1'b0); tick();
    drive(4, 36, 0, 1'b0); tick();
    drive(2, 40, 0, 1'b0); tick();
    chk("pre_wrap_count", 64'(bus.o_count), 64'd10);
    chk("pre_wrap_l0", lane(0), rec(32));
    chk("pre_wrap_l3", lane(3), rec(35));
    drive(4, 42, 2, 1'b0); tick();
    chk("wrap_count", 64'(bus.o_count), 64'd12);
    chk("wrap_l0", lane(0), rec(34));
    chk("wrap_l1", lane(1), rec(35));
    chk("wrap_l2", lane(2), rec(36));
    chk("wrap_l3", lane(3), rec(37));

    // oversized counts are clamped to the lane widths
    drive(7, 50, 0, 1'b0); tick();
    chk("enq_clamp_count", 64'(bus.o_count), 64'd16);
    chk("enq_clamp_ready", 64'(bus.o_enq_ready), 64'd0);
    drive(0, 0, 7, 1'b0); tick();
    drive(0, 0, 0, 1'b0);
    chk("deq_clamp_count", 64'(bus.o_count), 64'd12);
    chk("deq_clamp_l0", lane(0), rec(38));

    // reset overrides a flush-free enqueue in flight
    i_rst = 1'b1;
    drive(4, 70, 2, 1'b0); tick();
    i_rst = 1'b0;
    drive(0, 0, 0, 1'b0);
    chk("rst2_count", 64'(bus.o_count), 64'd0);
    chk("rst2_valid", 64'(bus.o_deq_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
